latch_bank_wr_ctrl: RTL and testbench
=====================================

# latch_bank_wr_ctrl

Write controller for a bank of level-sensitive D latches (each entry is a d/en latch built from a 2:1 mux). Several requesters share the bank's single data bus. The block arbitrates between them round-robin and sequences each write as setup, enable-open and hold phases, so data is stable around every enable pulse. It sits between the requesting logic and the latch bank and is the only driver of the bank's d and en inputs.

## Interface
Parameters:
- NREQ, 4, number of requesters
- DW, 8, data width of each latch entry
- DEPTH, 6, number of latch entries (1..2**AW)
- AW, 3, entry address width

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset
- req  input  NREQ  per-requester write request, level
- wr_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW]
- wr_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
- ack  output  NREQ  one-cycle pulse, write for requester i complete
- busy  output  1  high whenever FSM is not IDLE
- lat_d  output  DW  shared data bus to every latch d input
- lat_en  output  DEPTH  one-hot enable to latch entries
- err  output  1  one-cycle illegal-address pulse (only with LATCH_WR_ERR_EN)

## Operation
- FSM states: IDLE, SETUP, OPEN, HOLD.
- IDLE: if any req is high, pick a winner by round-robin starting at pointer ptr. On that edge, capture the winner's index, address and data into internal registers and go to SETUP. If no req is high, stay in IDLE.
- SETUP: lat_d = captured data; lat_en = 0. Go to OPEN.
- OPEN: lat_en[addr] = 1 if addr < DEPTH, otherwise all 0. lat_d is unchanged. Go to HOLD.
- HOLD: lat_en = 0; lat_d is unchanged; ack[grant] = 1. ptr becomes (grant+1) mod NREQ. Go to IDLE.
- Requester rules:
  - Hold req, wr_addr and wr_data stable until the edge at which the grant is captured.
  - Drop req in the cycle after its ack, unless it is posting a new write.
  - Changing inputs after the capture edge does not affect the write in flight.
- Every output is driven from a register; lat_en never glitches.
- lat_d keeps the last written value while in IDLE.
- Reset values:
  - outputs: lat_en = 0, lat_d = 0, ack = 0, busy = 0, err = 0
  - internal: state = IDLE, ptr = 0
- Reset mid-write: the write is abandoned.
  - lat_en = 0 from the next cycle.
  - No ack is issued for the abandoned write.
  - The latch entry may hold partial/new data; the requester must reissue the write.

## Timing
- IDLE edge with req sampled = cycle 0, then:
  - cycle 1: SETUP
  - cycle 2: OPEN (lat_en high)
  - cycle 3: HOLD (ack high)
  - cycle 4: IDLE, able to accept the next request
- Throughput: one write per 4 cycles. lat_d is stable from cycle 1 through at least cycle 3.
- Simultaneous requests: the lowest index at or above ptr wins, wrapping past NREQ-1 to 0. A held request waits at most NREQ-1 grants.
- Requests arriving in non-IDLE states are ignored until the next IDLE cycle.

## Configuration
- LATCH_WR_ERR_EN defined:
  - err port exists.
  - A write with addr >= DEPTH opens no enable, pulses err together with ack in HOLD, and still advances ptr.
- LATCH_WR_ERR_EN undefined:
  - err port and its logic are absent.
  - An illegal-address write is silently dropped: no enable, ack still issued, ptr advances.

## Structure
- Shared package latch_ctrl_pkg holds:
  - state encoding constants: IDLE=2'd0, SETUP=2'd1, OPEN=2'd2, HOLD=2'd3
  - default widths: DW, AW
  - the phase-count constant 4 used by benches
- One sub-module, latch_rr_arb: combinational round-robin arbiter.
  - Inputs: req, ptr.
  - Outputs: one-hot grant and grant index.
  - The top level owns the FSM, capture registers and the ptr update.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> lat_en=0, ack=0, busy=0, lat_d=0; first grant after release goes to requester 0.
- Single write: req[1]=1, addr=2, data=8'hA5 -> lat_d=8'hA5 in cycles 1-3; lat_en=6'b000100 in cycle 2 only; ack=4'b0010 in cycle 3; busy low in cycle 4.
- Contention: req=4'b1111 held, each requester dropping req after its ack -> acks to 0,1,2,3 in cycles 3, 7, 11, 15; no enable overlap.
- Pointer wrap: after a grant to 3, assert req[0] and req[3] together -> requester 0 is granted first, then 3.
- Illegal address 7 (DEPTH=6):
  - With LATCH_WR_ERR_EN: lat_en stays 0; err and ack[g] both pulse in cycle 3.
  - Without it: ack only.
- Reset in OPEN: rst_n=0 at the cycle-2 edge -> lat_en=0 in cycle 3; no ack; ptr=0; the held request is re-granted after release.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch-bank write controller.
// Holds the FSM state encoding, default entry/address widths and the
// number of clock phases that one write occupies (used by benches).
package latch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } wr_state_t;

    localparam int LATCH_DEF_DW    = 8;
    localparam int LATCH_DEF_AW    = 3;
    localparam int LATCH_WR_PHASES = 4;

endpackage

// File: rtl/latch_rr_arb.sv
// Combinational round-robin arbiter.
// Ports:
//   req       - request vector, one bit per requester
//   ptr       - index of the requester with highest priority this round
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - binary index of the granted requester
//   grant_vld - at least one request present
module latch_rr_arb #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_vld
);

    int w_idx;

    // Scan starting at ptr and wrapping; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!grant_vld && req[w_idx]) begin
                grant_vld    = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write controller for a bank of level-sensitive D latches.
// Arbitrates round-robin between requesters and sequences every write as
// SETUP (data on bus), OPEN (one enable high), HOLD (enable low, ack).
// Optional feature macro: LATCH_WR_ERR_EN adds the err output, which
// pulses with ack when the captured address is beyond DEPTH-1.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   req        - per-requester write request (level)
//   wr_addr    - requester i address in [i*AW +: AW]
//   wr_data    - requester i data in [i*DW +: DW]
//   ack        - one-cycle completion pulse per requester
//   busy       - controller is in the middle of a write
//   lat_d      - shared latch data bus
//   lat_en     - one-hot latch enables
//   err        - illegal-address pulse (LATCH_WR_ERR_EN only)
module latch_bank_wr_ctrl
    import latch_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = LATCH_DEF_DW,
    parameter int DEPTH = 6,
    parameter int AW    = LATCH_DEF_AW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*AW-1:0]  wr_addr,
    input  logic [NREQ*DW-1:0]  wr_data,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic [DW-1:0]       lat_d,
    output logic [DEPTH-1:0]    lat_en
`ifdef LATCH_WR_ERR_EN
    ,
    output logic                err
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_state_t        r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, r_gidx, w_gidx;
    logic [NREQ-1:0]  r_grant, w_grant;
    logic             w_gvld, w_capture, w_addr_ok;
    logic [AW-1:0]    r_addr;
    logic [DEPTH-1:0] r_lat_en, w_en_nxt;
    logic [NREQ-1:0]  r_ack, w_ack_nxt;
    logic [DW-1:0]    r_lat_d;
    logic             r_busy;

    latch_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req       (req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx),
        .grant_vld (w_gvld)
    );

    // Next state plus the registered-output values that go with it, so each
    // output register already holds the right value on entering a state.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_en_nxt    = '0;
        w_ack_nxt   = '0;
        w_addr_ok   = (int'(r_addr) < DEPTH);
        case (r_state)
            IDLE: begin
                if (w_gvld) begin
                    w_state_nxt = SETUP;
                    w_capture   = 1'b1;
                end
            end
            SETUP:   w_state_nxt = OPEN;
            OPEN:    w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == OPEN && w_addr_ok) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (int'(r_addr) == e) begin
                    w_en_nxt[e] = 1'b1;
                end
            end
        end
        if (w_state_nxt == HOLD) begin
            w_ack_nxt = r_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_lat_en <= '0;
            r_lat_d  <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lat_en <= w_en_nxt;
            r_ack    <= w_ack_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            // Data goes onto the bus at capture so it is stable before OPEN.
            if (w_capture) begin
                r_lat_d <= wr_data[w_gidx*DW +: DW];
            end
            if (r_state == HOLD) begin
                r_ptr <= (r_gidx == PW'(NREQ-1)) ? '0 : r_gidx + 1'b1;
            end
        end
    end

    // Capture registers carry no reset: they are only read after a capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_gidx  <= w_gidx;
            r_grant <= w_grant;
            r_addr  <= wr_addr[w_gidx*AW +: AW];
        end
    end

`ifdef LATCH_WR_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == HOLD) && !w_addr_ok;
        end
    end

    assign err = r_err;
`endif

    assign lat_en = r_lat_en;
    assign lat_d  = r_lat_d;
    assign ack    = r_ack;
    assign busy   = r_busy;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Self-checking bench for latch_bank_wr_ctrl (default parameters).
module tb_latch_bank_wr_ctrl;
    import latch_ctrl_pkg::*;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  wr_addr;
    logic [NREQ*DW-1:0]  wr_data;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic [DW-1:0]       lat_d;
    logic [DEPTH-1:0]    lat_en;
    logic                err_w;

    logic [AW-1:0] a [NREQ];
    logic [DW-1:0] d [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            wr_addr[i*AW +: AW] = a[i];
            wr_data[i*DW +: DW] = d[i];
        end
    end

    latch_bank_wr_ctrl #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ack     (ack),
        .busy    (busy),
        .lat_d   (lat_d),
        .lat_en  (lat_en)
`ifdef LATCH_WR_ERR_EN
        ,
        .err     (err_w)
`endif
    );

`ifndef LATCH_WR_ERR_EN
    assign err_w = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic            rst_n;
        logic [NREQ-1:0] req;
        logic [AW-1:0]   a0, a1;
        logic [DW-1:0]   d0, d1;
        logic [DEPTH-1:0] en;
        logic [NREQ-1:0] ack;
        logic            busy;
        logic [DW-1:0]   latd;
    } vec_t;

    vec_t tv [11];

    // Transaction-level reference: a write occupies LATCH_WR_PHASES cycles
    // counted from capture; outputs follow from the cycle offset.
    int            m_t, m_ptr, m_g, m_addr;
    logic [DW-1:0] m_latd;

    task automatic model_step();
        if (!rst_n) begin
            m_t = 0; m_ptr = 0; m_latd = '0;
        end else if (m_t == 0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
            end
            if (req != 0) begin
                m_addr = int'(a[m_g]);
                m_latd = d[m_g];
                m_t    = 1;
            end
        end else if (m_t == LATCH_WR_PHASES - 1) begin
            m_ptr = (m_g + 1) % NREQ;
            m_t   = 0;
        end else begin
            m_t++;
        end
    endtask

    function automatic logic [19:0] model_out();
        logic [DEPTH-1:0] en;
        logic [NREQ-1:0]  ak;
        logic             er;
        en = '0; ak = '0; er = 1'b0;
        if (m_t == 2 && m_addr < DEPTH) en[m_addr] = 1'b1;
        if (m_t == 3) ak[m_g] = 1'b1;
`ifdef LATCH_WR_ERR_EN
        er = (m_t == 3) && (m_addr >= DEPTH);
`endif
        return {er, (m_t != 0), ak, en, m_latd};
    endfunction

    initial begin
        logic [NREQ-1:0] q [$];
        logic [NREQ-1:0] seen;
        logic [NREQ-1:0] last_ack;
        logic            pend [NREQ];

        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            d[i] = '0;
        end

        // ---------------- table: reset + single write ----------------
        tv[0]  = '{1'b0, 4'b1111, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b0, 8'h00};
        tv[1]  = '{1'b0, 4'b1111, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b0, 8'h00};
        tv[2]  = '{1'b1, 4'b1111, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b1, 8'h11};
        tv[3]  = '{1'b1, 4'b1111, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000010, 4'b0000, 1'b1, 8'h11};
        tv[4]  = '{1'b1, 4'b1111, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0001, 1'b1, 8'h11};
        tv[5]  = '{1'b1, 4'b0010, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b0, 8'h11};
        tv[6]  = '{1'b1, 4'b0010, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b1, 8'hA5};
        tv[7]  = '{1'b1, 4'b0010, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000100, 4'b0000, 1'b1, 8'hA5};
        tv[8]  = '{1'b1, 4'b0010, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0010, 1'b1, 8'hA5};
        tv[9]  = '{1'b1, 4'b0000, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b0, 8'hA5};
        tv[10] = '{1'b1, 4'b0000, 3'd1, 3'd2, 8'h11, 8'hA5, 6'b000000, 4'b0000, 1'b0, 8'hA5};

        #2;
        for (int v = 0; v < 11; v++) begin
            rst_n = tv[v].rst_n;
            req   = tv[v].req;
            a[0]  = tv[v].a0;  a[1] = tv[v].a1;
            d[0]  = tv[v].d0;  d[1] = tv[v].d1;
            tick();
            chk($sformatf("vec%0d_en", v),   lat_en, tv[v].en);
            chk($sformatf("vec%0d_ack", v),  ack,    tv[v].ack);
            chk($sformatf("vec%0d_busy", v), busy,   tv[v].busy);
            chk($sformatf("vec%0d_latd", v), lat_d,  tv[v].latd);
        end

        // ---------------- contention: all four held ----------------
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'(i);
            d[i] = DW'(8'h40 + i);
        end
        req = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk("contend_ack", ack,
                (c >= 3 && c <= 15 && (c - 3) % 4 == 0) ? 32'(1 << ((c - 3) / 4)) : 32'd0);
            chk("contend_en_onehot", ($countones(lat_en) <= 1), 1);
            req = req & ~ack;
        end

        // ---------------- pointer wrap after grant to 3 ----------------
        q.delete();
        req = 4'b1001;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ack != 0) q.push_back(ack);
            req = req & ~ack;
        end
        chk("wrap_count", q.size(), 2);
        chk("wrap_first",  (q.size() > 0) ? q[0] : 4'hF, 4'b0001);
        chk("wrap_second", (q.size() > 1) ? q[1] : 4'hF, 4'b1000);

        // ---------------- illegal address ----------------
        do_reset();
        a[2] = 3'd7; d[2] = 8'h3C;
        req  = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("illegal_en", lat_en, 0);
            chk("illegal_ack", ack, (c == 3) ? 4'b0100 : 4'b0000);
`ifdef LATCH_WR_ERR_EN
            chk("illegal_err", err_w, (c == 3));
`endif
            if (c == 2) chk("illegal_latd", lat_d, 8'h3C);
            req = req & ~ack;
        end
        // ptr must have moved past requester 2
        a[3] = 3'd3;
        req  = 4'b1100;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (seen == 0) seen = ack;
        end
        chk("illegal_ptr_adv", seen, 4'b1000);
        req = '0;
        tick(); tick(); tick();

        // ---------------- reset during OPEN ----------------
        do_reset();
        a[2] = 3'd0;
        req  = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            req = req & ~ack;
        end
        a[1] = 3'd0; d[1] = 8'h5A;
        req  = 4'b0010;
        tick();
        tick();
        chk("rstopen_en_before", lat_en, 6'b000001);
        rst_n = 1'b0;
        tick();
        chk("rstopen_en", lat_en, 0);
        chk("rstopen_ack", ack, 0);
        chk("rstopen_busy", busy, 0);
        rst_n = 1'b1;
        a[3] = 3'd1;
        req  = 4'b1010;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (seen == 0) seen = ack;
        end
        chk("rstopen_regrant", seen, 4'b0010);

        // ---------------- randomized against model ----------------
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        last_ack = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = (cyc < 2 || $urandom_range(63, 0) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (last_ack[i]) begin
                    pend[i] = ($urandom_range(1, 0) == 1);
                    if (pend[i]) begin
                        a[i] = AW'($urandom_range(7, 0));
                        d[i] = DW'($urandom);
                    end
                end else if (!pend[i] && $urandom_range(3, 0) == 0) begin
                    pend[i] = 1'b1;
                    a[i] = AW'($urandom_range(7, 0));
                    d[i] = DW'($urandom);
                end
                req[i] = pend[i];
            end
            model_step();
            tick();
            chk("random", {err_w, busy, ack, lat_en, lat_d}, model_out());
            last_ack = ack;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
